// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter that shares the register-file write port
// between the ALU path (A) and the load/mul-div path (B).
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hold,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              last_grant,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic              grant_a;
    logic              grant_b;
    logic [ADDR_W-1:0] win_reg;
    logic [DATA_W-1:0] win_data;
    logic              last_grant_reg;
    logic              last_grant_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic              reg_write_reg;
    logic [ADDR_W-1:0] write_reg_reg;
    logic [DATA_W-1:0] write_data_reg;

    // On contention the port that did not win last time is favoured.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset && !hold) begin
            if (a_valid && (!b_valid || last_grant_reg)) begin
                grant_a = 1'b1;
            end else if (b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    always_comb begin
        win_reg         = grant_b ? b_reg : a_reg;
        win_data        = grant_b ? b_data : a_data;
        last_grant_next = last_grant_reg;
        if (grant_a) begin
            last_grant_next = 1'b0;
        end else if (grant_b) begin
            last_grant_next = 1'b1;
        end
        cnt_next = cnt_reg;
        if (a_valid && b_valid && !hold && !(&cnt_reg)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_reg <= 1'b1;
            cnt_reg        <= '0;
            reg_write_reg  <= 1'b0;
            write_reg_reg  <= '0;
            write_data_reg <= '0;
        end else begin
            last_grant_reg <= last_grant_next;
            cnt_reg        <= cnt_next;
            // Register-0 winners still handshake but never assert the write.
            if (grant_a || grant_b) begin
                reg_write_reg  <= (win_reg != '0);
                write_reg_reg  <= win_reg;
                write_data_reg <= win_data;
            end else begin
                reg_write_reg  <= 1'b0;
            end
        end
    end

    assign a_ready      = grant_a;
    assign b_ready      = grant_b;
    assign RegWrite     = reg_write_reg;
    assign WriteReg     = write_reg_reg;
    assign WriteData    = write_data_reg;
    assign last_grant   = last_grant_reg;
    assign conflict_cnt = cnt_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: table-driven vectors plus hand sequences,
// with a reference model feeding an expected-output queue.
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        hold = 1'b0;
    logic        a_valid = 1'b0;
    logic [4:0]  a_reg = '0;
    logic [31:0] a_data = '0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [4:0]  b_reg = '0;
    logic [31:0] b_data = '0;
    logic        b_ready;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        last_grant;
    logic [7:0]  conflict_cnt;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .hold(hold),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .last_grant(last_grant), .conflict_cnt(conflict_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        h;
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  br;
        logic [31:0] bd;
        logic        ra;
        logic        rb;
    } vec_t;

    typedef struct {
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        lg;
        logic [7:0]  cnt;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int txn = 0;

    // reference model state
    logic        m_last;
    logic [7:0]  m_cnt;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    logic        samp_ra;
    logic        samp_rb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 1'b1;
        m_cnt  = '0;
        m_wr   = '0;
        m_wd   = '0;
        sb.delete();
    endtask

    task automatic step(input logic h, input logic av, input logic [4:0] ar,
                        input logic [31:0] ad, input logic bv, input logic [4:0] br,
                        input logic [31:0] bd);
        logic ga, gb;
        exp_t e, got;
        @(negedge clock);
        hold = h; a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        ga = !h && av && (!bv || m_last);
        gb = !h && bv && (!av || !m_last);
        #1;
        samp_ra = a_ready;
        samp_rb = b_ready;
        check("a_ready", {63'd0, a_ready}, {63'd0, ga});
        check("b_ready", {63'd0, b_ready}, {63'd0, gb});
        e.rw = 1'b0;
        if (ga) begin
            e.rw = (ar != 5'd0); m_wr = ar; m_wd = ad; m_last = 1'b0;
        end else if (gb) begin
            e.rw = (br != 5'd0); m_wr = br; m_wd = bd; m_last = 1'b1;
        end
        if (av && bv && !h && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        e.wr = m_wr; e.wd = m_wd; e.lg = m_last; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            got = sb.pop_front();
            check("RegWrite", {63'd0, RegWrite}, {63'd0, got.rw});
            check("WriteReg", {59'd0, WriteReg}, {59'd0, got.wr});
            check("WriteData", {32'd0, WriteData}, {32'd0, got.wd});
            check("last_grant", {63'd0, last_grant}, {63'd0, got.lg});
            check("conflict_cnt", {56'd0, conflict_cnt}, {56'd0, got.cnt});
        end
        txn++;
        $display("txn %0d: hold=%0b a=%0b/%0d b=%0b/%0d rdy=%0b%0b -> we=%0b reg=%0d data=%h lg=%0b cnt=%0d",
                 txn, h, av, ar, bv, br, samp_ra, samp_rb, RegWrite, WriteReg, WriteData,
                 last_grant, conflict_cnt);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_RegWrite"}, {63'd0, RegWrite}, 64'd0);
        check({tag, "_WriteReg"}, {59'd0, WriteReg}, 64'd0);
        check({tag, "_WriteData"}, {32'd0, WriteData}, 64'd0);
        check({tag, "_conflict_cnt"}, {56'd0, conflict_cnt}, 64'd0);
        check({tag, "_last_grant"}, {63'd0, last_grant}, 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        #1 check_reset_values("rst");
        model_reset();
        @(negedge clock);
        hold = 0; a_valid = 0; b_valid = 0;
        reset = 1'b0;
    endtask

    initial begin
        // hold ra rb expectations are from a fresh reset (last_grant=1)
        vecs[0] = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,       1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,       1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 5'd9,  32'h99,       1'b1, 5'd10, 32'hAA,       1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 32'h12345678, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 5'd0,  32'hAAAA,     1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 5'd6,  32'h66,       1'b0, 5'd0,  32'h0,        1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b1, 5'd6,  32'h66,       1'b1, 5'd7,  32'h77,       1'b0, 1'b1};

        // asynchronous reset asserted between edges
        #2 reset = 1'b1;
        #1 check_reset_values("por");
        model_reset();
        @(negedge clock);
        a_valid = 1; b_valid = 1;
        #1;
        check("ready_in_reset", {62'd0, a_ready, b_ready}, 64'd0);
        @(negedge clock);
        a_valid = 0; b_valid = 0;
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].h, vecs[i].av, vecs[i].ar, vecs[i].ad,
                 vecs[i].bv, vecs[i].br, vecs[i].bd);
            check($sformatf("vec%0d_a_ready", i), {63'd0, samp_ra}, {63'd0, vecs[i].ra});
            check($sformatf("vec%0d_b_ready", i), {63'd0, samp_rb}, {63'd0, vecs[i].rb});
        end
        step(0, 0, 0, 0, 0, 0, 0);

        // contention from reset: A first, then B once A drops
        do_reset();
        step(0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
        check("cont1_WriteReg", {59'd0, WriteReg}, 64'd3);
        check("cont1_cnt", {56'd0, conflict_cnt}, 64'd1);
        step(0, 0, 5'd3, 32'h11, 1, 5'd4, 32'h22);
        check("cont2_WriteData", {32'd0, WriteData}, 64'h22);
        check("cont2_cnt", {56'd0, conflict_cnt}, 64'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        check("cont3_RegWrite", {63'd0, RegWrite}, 64'd0);

        // grant right before hold shows up in first hold cycle
        step(0, 1, 5'd8, 32'h88, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 5'd9, 32'h99, 1, 5'd10, 32'hAA);
        step(0, 1, 5'd9, 32'h99, 1, 5'd10, 32'hAA);
        check("hold_release_b_first", {62'd0, samp_ra, samp_rb}, 64'b01);

        // reset mid-cycle drops the pending grant
        @(negedge clock);
        a_valid = 1; a_reg = 5'd7; a_data = 32'h77; b_valid = 0; hold = 0;
        #1 check("pre_rst_a_ready", {63'd0, a_ready}, 64'd1);
        #2 reset = 1'b1;
        #1 check("rst_a_ready", {63'd0, a_ready}, 64'd0);
        check_reset_values("mid");
        model_reset();
        @(posedge clock);
        #1 check("rst_drop_RegWrite", {63'd0, RegWrite}, 64'd0);
        @(negedge clock);
        a_valid = 0;
        reset = 1'b0;

        // saturation under continuous contention
        for (int i = 0; i < 300; i++) step(0, 1, 5'd1, i, 1, 5'd2, ~i);
        check("sat_cnt", {56'd0, conflict_cnt}, 64'd255);
        step(0, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter that shares the single write port of the 32x32 register file between two requesters: the ALU write-back path (port A) and the multi-cycle load/mul-div path (port B). Each requester presents a destination register and data under a valid/ready handshake. The block grants at most one request per cycle using round-robin on contention and registers the winner onto the register-file write signals. It suppresses writes to register 0 and keeps a saturating contention counter for performance monitoring.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register index width
- CNT_W, 8, contention counter width

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- hold  in  1  freeze arbitration; no grants while 1
- a_valid  in  1  port A request
- a_reg  in  ADDR_W  port A destination register
- a_data  in  DATA_W  port A write data
- a_ready  out  1  port A granted this cycle
- b_valid  in  1  port B request
- b_reg  in  ADDR_W  port B destination register
- b_data  in  DATA_W  port B write data
- b_ready  out  1  port B granted this cycle
- RegWrite  out  1  register-file write enable (registered)
- WriteReg  out  ADDR_W  register-file write index (registered)
- WriteData  out  DATA_W  register-file write data (registered)
- last_grant  out  1  0 = A won the last grant, 1 = B won the last grant
- conflict_cnt  out  CNT_W  saturating count of contention cycles

## Operation
- Handshake: a transfer occurs in the cycle where valid=1 and ready=1. The requester holds valid, reg and data stable until ready. Ready is a combinational function of both valids, hold and last_grant. Ready is never asserted while its own valid is 0.
- Grant rules when hold=0:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the port opposite to last_grant.
- When hold=1, a_ready=b_ready=0 and no state changes except the registered outputs, which clear RegWrite.
- last_grant updates on every grant to the granted port. It is unchanged in cycles with no grant.
- Output stage: on a grant, the next edge loads WriteReg/WriteData with the winner's reg/data. RegWrite is 1 only if the winner's reg is nonzero.
- Register-0 writes still complete the handshake (ready=1), so the requester is not stalled. They produce RegWrite=0.
- On a no-grant cycle, the next edge sets RegWrite=0. WriteReg and WriteData hold their previous values.
- conflict_cnt increments by 1 on each edge where a_valid=b_valid=1 and hold=0. It saturates at 2^CNT_W-1 and does not wrap.
- Both ports targeting the same register is not special-cased. The writes commit in grant order, so the later grant wins in the register file.

## Timing
- Reset (async, immediate, active-high) sets:
  - RegWrite=0, WriteReg=0, WriteData=0
  - last_grant=1, so A wins the first contention
  - conflict_cnt=0
- While reset is asserted, a_ready=b_ready=0.
- Latency: a grant in cycle N gives RegWrite/WriteReg/WriteData valid during cycle N+1, so the register file captures the write at the end of N+1.
- Throughput: one grant per cycle. Under continuous contention, grants alternate A,B,A,B…
- A port loses at most one consecutive contention cycle, so its worst-case wait is 1 cycle while hold=0.
- hold asserted mid-stream: the grant in the cycle before hold still appears on the outputs in the first hold cycle. Subsequent hold cycles give RegWrite=0.
- Reset asserted mid-operation: a pending output write is dropped, and requesters must re-present their requests after reset.

## Test plan
- Reset then idle: assert reset asynchronously between edges -> RegWrite=0, WriteReg=0, WriteData=0, conflict_cnt=0, last_grant=1 immediately, before the next edge.
- Single port: A presents reg=5, data=0xDEADBEEF for 1 cycle -> a_ready=1 that cycle; next cycle RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF; the following cycle RegWrite=0.
- Contention round-robin: A (reg 3, 0x11) and B (reg 4, 0x22) both held valid from reset -> grants A then B. Outputs show reg3/0x11, then reg4/0x22 on consecutive cycles. conflict_cnt=1 after the first edge and remains 1 once A drops.
- Register-0 suppression: B presents reg=0, data=0xFFFFFFFF -> b_ready=1; next cycle RegWrite=0; last_grant=1.
- Hold: both valid with hold=1 for 3 cycles -> ready=0 on both, RegWrite=0, conflict_cnt unchanged. On releasing hold, the port opposite to last_grant is granted first.
- Saturation: with CNT_W=8, hold both valid for 300 cycles -> conflict_cnt stops at 255, and grants alternate throughout.
